// File: rtl/toy_fetch_buffer.sv
// Per-lane instruction FIFO for the fetch queue: compacting multi-entry write port,
// single-entry valid/ready drain port, and a synchronous flush on pipeline redirect.
module toy_fetch_buffer #(
    parameter int DEPTH      = 16,
    parameter int MUX_IN     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int RAW_INST_W = 32,
    parameter int FE_WIDTH   = 8,
    localparam int ENTRY_W   = ADDR_WIDTH + RAW_INST_W + FE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cancel_en,
    output logic                      req_rdy,
    input  logic                      req_vld,
    input  logic [MUX_IN*ENTRY_W-1:0] v_req_pld,
    input  logic [MUX_IN-1:0]         v_req_en,
    output logic                      v_ack_vld,
    input  logic                      v_ack_rdy,
    output logic [ADDR_WIDTH-1:0]     v_ack_pc,
    output logic [INST_WIDTH-1:0]     v_ack_pld,
    output logic [FE_WIDTH-1:0]       v_fe_pld
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(MUX_IN + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   count;
    logic [CNT_W-1:0]   n_wr;
    logic [IDX_W-1:0]   slot;
    logic               wr_fire;
    logic               rd_fire;
    logic [ENTRY_W-1:0] head;

    // Wrap bit in the MSB lets count reach DEPTH without ambiguity.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign req_rdy   = (PTR_W'(DEPTH) - count) >= PTR_W'(MUX_IN);
    assign v_ack_vld = (count != '0);
    assign wr_fire   = req_vld & req_rdy;
    assign rd_fire   = v_ack_vld & v_ack_rdy;

    assign head      = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign v_ack_pc  = head[ADDR_WIDTH-1:0];
    assign v_ack_pld = INST_WIDTH'(head[ADDR_WIDTH +: RAW_INST_W]);
    assign v_fe_pld  = head[ADDR_WIDTH+RAW_INST_W +: FE_WIDTH];

    // Enabled entries are packed into consecutive slots in index order.
    always_comb begin
        mem_d = mem_q;
        n_wr  = '0;
        slot  = '0;
        for (int i = 0; i < MUX_IN; i++) begin
            if (v_req_en[i]) begin
                slot = wr_ptr_q[IDX_W-1:0] + IDX_W'(n_wr);
                if (wr_fire && !cancel_en) begin
                    mem_d[slot] = v_req_pld[i*ENTRY_W +: ENTRY_W];
                end
                n_wr = n_wr + CNT_W'(1);
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (cancel_en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_toy_fetch_buffer.sv
// Scoreboard bench for toy_fetch_buffer: a queue model tracks accepted entries and
// every pop is compared in order; handshake flags are compared every cycle.
module tb_toy_fetch_buffer;

    localparam int DEPTH      = 16;
    localparam int MUX_IN     = 2;
    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 32;
    localparam int RAW_INST_W = 32;
    localparam int FE_WIDTH   = 8;
    localparam int ENTRY_W    = ADDR_WIDTH + RAW_INST_W + FE_WIDTH;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      cancel_en;
    logic                      req_rdy;
    logic                      req_vld;
    logic [MUX_IN*ENTRY_W-1:0] v_req_pld;
    logic [MUX_IN-1:0]         v_req_en;
    logic                      v_ack_vld;
    logic                      v_ack_rdy;
    logic [ADDR_WIDTH-1:0]     v_ack_pc;
    logic [INST_WIDTH-1:0]     v_ack_pld;
    logic [FE_WIDTH-1:0]       v_fe_pld;

    logic [ENTRY_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int pc_next;

    toy_fetch_buffer #(
        .DEPTH(DEPTH), .MUX_IN(MUX_IN), .ADDR_WIDTH(ADDR_WIDTH),
        .INST_WIDTH(INST_WIDTH), .RAW_INST_W(RAW_INST_W), .FE_WIDTH(FE_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cancel_en(cancel_en),
        .req_rdy(req_rdy), .req_vld(req_vld), .v_req_pld(v_req_pld),
        .v_req_en(v_req_en), .v_ack_vld(v_ack_vld), .v_ack_rdy(v_ack_rdy),
        .v_ack_pc(v_ack_pc), .v_ack_pld(v_ack_pld), .v_fe_pld(v_fe_pld)
    );

    always #5 clk = ~clk;

    function automatic logic [ENTRY_W-1:0] mk(input logic [31:0] pc);
        logic [31:0] inst;
        logic [7:0]  fe;
        inst = pc ^ 32'hDEAD_0000;
        fe   = pc[9:2] ^ 8'h5A;
        return {fe, inst, pc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, update model at posedge.
    task automatic cycle(input logic vld, input logic [1:0] en,
                         input logic [ENTRY_W-1:0] e0, input logic [ENTRY_W-1:0] e1,
                         input logic rdy, input logic cxl);
        logic [ENTRY_W-1:0] front;
        logic m_rdy;
        req_vld   = vld;
        v_req_en  = en;
        v_req_pld = {e1, e0};
        v_ack_rdy = rdy;
        cancel_en = cxl;
        @(negedge clk);
        m_rdy = (exp_q.size() <= DEPTH - MUX_IN);
        chk("req_rdy", 64'(req_rdy), 64'(m_rdy));
        chk("v_ack_vld", 64'(v_ack_vld), 64'(exp_q.size() != 0));
        if (rdy && exp_q.size() != 0) begin
            front = exp_q[0];
            chk("head_pc", 64'(v_ack_pc), 64'(front[ADDR_WIDTH-1:0]));
            chk("head_inst", 64'(v_ack_pld), 64'(front[ADDR_WIDTH +: RAW_INST_W]));
            chk("head_fe", 64'(v_fe_pld), 64'(front[ADDR_WIDTH+RAW_INST_W +: FE_WIDTH]));
        end
        @(posedge clk);
        if (cxl) begin
            exp_q.delete();
        end else begin
            if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
            if (vld && m_rdy) begin
                if (en[0]) exp_q.push_back(e0);
                if (en[1]) exp_q.push_back(e1);
            end
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 2'b00, '0, '0, rdy, 1'b0);
    endtask

    task automatic wr2(input logic rdy);
        cycle(1'b1, 2'b11, mk(32'(pc_next)), mk(32'(pc_next + 4)), rdy, 1'b0);
        pc_next += 8;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) idle(1'b1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(1'b0);
    endtask

    initial begin
        rst_n = 1'b0; cancel_en = 1'b0; req_vld = 1'b0;
        v_req_pld = '0; v_req_en = '0; v_ack_rdy = 1'b0;
        pc_next = 32'h1000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_req_rdy", 64'(req_rdy), 64'd1);
        chk("rst_ack_vld", 64'(v_ack_vld), 64'd0);

        // Basic two-entry write then two pops, then pop while empty.
        cycle(1'b1, 2'b11, mk(32'h100), mk(32'h104), 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Sparse enable mask and a zero-entry handshake.
        cycle(1'b1, 2'b10, mk(32'h1FC), mk(32'h200), 1'b0, 1'b0);
        cycle(1'b1, 2'b00, mk(32'h300), mk(32'h304), 1'b0, 1'b0);
        idle(1'b0);
        drain();

        // Fill to full; writes refused while full; pops reopen the port.
        for (int i = 0; i < 8; i++) wr2(1'b0);
        idle(1'b0);
        cycle(1'b1, 2'b11, mk(32'hBAD0), mk(32'hBAD4), 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        drain();

        // Continuous writes and pops across the pointer wrap.
        for (int i = 0; i < 40; i++) wr2(1'b1);
        drain();

        // Cancel with a concurrent write and pop.
        wr2(1'b0); wr2(1'b0);
        cycle(1'b1, 2'b01, mk(32'h500), mk(32'h504), 1'b0, 1'b0);
        cycle(1'b1, 2'b11, mk(32'h600), mk(32'h604), 1'b1, 1'b1);
        idle(1'b0);
        cycle(1'b1, 2'b11, mk(32'h700), mk(32'h704), 1'b0, 1'b0);
        idle(1'b1);
        drain();

        // Write two and pop one while holding a single entry.
        cycle(1'b1, 2'b01, mk(32'h800), mk(32'h804), 1'b0, 1'b0);
        cycle(1'b1, 2'b11, mk(32'h900), mk(32'h904), 1'b1, 1'b0);
        idle(1'b1);
        drain();

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  mk(32'(pc_next)), mk(32'(pc_next + 4)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
            pc_next += 8;
        end
        drain();

        // Asynchronous reset mid-operation.
        wr2(1'b0); wr2(1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 64'(v_ack_vld), 64'd0);
        chk("async_rst_rdy", 64'(req_rdy), 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        wr2(1'b0);
        idle(1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/toy_fetch_buffer.md
Name: toy_fetch_buffer

Overview:
- Per-lane instruction FIFO inside the fetch queue; one instance per read channel.
- Each write cycle accepts up to MUX_IN instructions under an enable mask. Enabled entries are compacted in index order and stored in consecutive slots.
- Entries drain one per cycle through a valid/ready port that exposes PC, instruction word and front-end bypass payload.
- A cancel input flushes the buffer on pipeline redirect.

Parameters:
- DEPTH, 16, number of entries; power of two, DEPTH >= MUX_IN.
- MUX_IN, 2, write-port width (entries offered per write handshake).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- cancel_en  in  1  synchronous flush.
- req_rdy  out  1  buffer can accept a full MUX_IN-wide write.
- req_vld  in  1  write request valid.
- v_req_pld  in  fetch_queue_pkg[MUX_IN]  candidate entries; index 0 is oldest.
- v_req_en  in  MUX_IN  per-entry write enable.
- v_ack_vld  out  1  head entry valid.
- v_ack_rdy  in  1  consumer pops the head.
- v_ack_pc  out  ADDR_WIDTH  head PC.
- v_ack_pld  out  INST_WIDTH  head instruction word.
- v_fe_pld  out  fe_bypass_pkg  head front-end bypass payload.

Behaviour:
- Reset rst_n, asynchronous, active-low; clock clk.
- Reset state: wr_ptr=rd_ptr=0 (log2(DEPTH)+1 bits, MSB is the wrap bit); req_rdy=1, v_ack_vld=0.
- Storage is not reset. v_ack_pc, v_ack_pld and v_fe_pld are don't-care while v_ack_vld=0.
- count = wr_ptr - rd_ptr, range 0..DEPTH. Empty when count=0. Full when count=DEPTH (pointer low bits equal, wrap bits differ).
- req_rdy = (DEPTH - count) >= MUX_IN.
  - Computed from registered count only; it ignores v_req_en and any pop in the same cycle.
  - It is independent of req_vld.
- Write fires when req_vld & req_rdy.
  - n = popcount(v_req_en) entries are written.
  - The k-th set bit of v_req_en (lowest index first) is written to slot (wr_ptr + k) mod DEPTH.
  - wr_ptr advances by n. n=0 is a legal handshake that writes nothing.
- v_ack_vld = ~empty. The head is slot rd_ptr mod DEPTH.
- Outputs are driven combinationally from the head entry:
  - v_ack_pc = entry PC field;
  - v_ack_pld = entry instruction field, zero-extended to INST_WIDTH;
  - v_fe_pld = entry fe_bypass fields.
- Pop fires when v_ack_vld & v_ack_rdy; rd_ptr advances by 1. v_ack_rdy while empty has no effect.
- Latency: an entry written at edge t appears at the head earliest in cycle t+1. There is no same-cycle write-to-read bypass.
- Simultaneous write and pop in one cycle are both applied: wr_ptr += n, rd_ptr += 1.
- Pointers wrap modulo 2*DEPTH. Ordering is preserved across the wrap.
- cancel_en=1 at an edge sets wr_ptr=rd_ptr=0.
  - This overrides any write or pop in that cycle; the buffer is empty from the next cycle on.
  - Storage contents are left untouched.
- Asserting rst_n low mid-operation immediately forces the empty state.

Test Plan:
- Reset, then req_vld=1, v_req_en=2'b11, entries PC 0x100 and 0x104 -> next cycle v_ack_vld=1 with v_ack_pc=0x100. Pop one -> head becomes 0x104. Pop again -> v_ack_vld=0.
- Write v_req_en=2'b10 carrying entry1 PC 0x200 -> only 0x200 is stored (count=1). A following write with v_req_en=2'b00 -> count unchanged, req_rdy stays 1.
- Fill with DEPTH=16 using 7 writes of two entries (count=14) -> req_rdy=1. One more two-entry write -> count=16, req_rdy=0, and req_vld is then ignored. Pop once -> count=15, req_rdy still 0. Pop again -> req_rdy=1.
- Drive continuous two-entry writes and pops for 40 cycles across the pointer wrap -> PCs are popped in strict write order with none lost or duplicated.
- With count=5, in one cycle assert cancel_en together with a write and a pop -> next cycle v_ack_vld=0 and count=0. A new write afterwards appears at the head one cycle later.
- In the same cycle write two entries and pop one while count=1 -> next cycle count=2, and the head is the first newly written entry.
